// File: rtl/gpio_box_tx.sv
// -----------------------------------------------------------------------------
// gpio_box_tx
//   Sends a 3-bit box address to the external sensor MCU over GPIO. It uses a
//   4-phase strobe/ack handshake, and each wait for an ack edge has a timeout.
//   The data pins are driven from a register that is latched when a request
//   is accepted. The MCU ack passes through a 2-flop synchroniser before the
//   FSM uses it.
//
// Ports
//   CLOCK_50      in   system clock (rising edge)
//   resetn        in   synchronous, active-low reset
//   send_req      in   transmit request, only honoured in IDLE
//   send_addr     in   [2:0] address to transmit
//   busy          out  high from the cycle after acceptance until back in IDLE
//   done          out  1-cycle pulse, handshake completed
//   timeout_err   out  1-cycle pulse, handshake aborted on timeout
//   GPIO_TX_DATA  out  [2:0] address pins to the MCU
//   GPIO_TX_STB   out  strobe pin to the MCU
//   GPIO_ACK_IN   in   ack pin from the MCU (asynchronous)
//   LEDR          out  [9:0] {sticky_err, 0000, ack_s, strobe, data}
// -----------------------------------------------------------------------------
module gpio_box_tx #(
  parameter int SETUP_CYCLES   = 50,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       send_req,
  input  logic [2:0] send_addr,
  output logic       busy,
  output logic       done,
  output logic       timeout_err,
  output logic [2:0] GPIO_TX_DATA,
  output logic       GPIO_TX_STB,
  input  logic       GPIO_ACK_IN,
  output logic [9:0] LEDR
);

  localparam int MAX_CYCLES = (SETUP_CYCLES > TIMEOUT_CYCLES) ? SETUP_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_RELEASE,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       data_q, data_d;
  logic             sticky_q, sticky_d;
  logic             ack_meta_q, ack_s_q;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             stb_q, stb_d;

  // Next state, counter and registered-output decode.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    sticky_d = sticky_q;

    unique case (state_q)
      ST_IDLE: begin
        if (send_req) begin
          data_d   = send_addr;
          sticky_d = 1'b0;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        // A stale ack holds us here; the timeout still applies while it does.
        // The ack test comes first so a release on the last cycle still proceeds.
        if (cnt_q >= SETUP_LAST && !ack_s_q) state_d = ST_STROBE;
        else if (cnt_q >= TIMEOUT_LAST)      state_d = ST_ERR;
      end
      ST_STROBE: begin
        if (ack_s_q)                    state_d = ST_RELEASE;
        else if (cnt_q >= TIMEOUT_LAST) state_d = ST_ERR;
      end
      ST_RELEASE: begin
        if (!ack_s_q)                   state_d = ST_DONE;
        else if (cnt_q >= TIMEOUT_LAST) state_d = ST_ERR;
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR: begin
        sticky_d = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // The counter restarts from zero on every state entry and idles at zero.
    if (state_q == ST_IDLE || state_d != state_q) cnt_d = '0;
    else                                          cnt_d = cnt_q + CNT_ONE;

    // The pins are decoded from the current state and then registered. This
    // adds one clock, so the strobe rises SETUP_CYCLES+1 clocks after acceptance.
    busy_d = (state_q != ST_IDLE);
    done_d = (state_q == ST_DONE);
    err_d  = (state_q == ST_ERR);
    stb_d  = (state_q == ST_STROBE);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      data_q     <= '0;
      sticky_q   <= 1'b0;
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      stb_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      sticky_q   <= sticky_d;
      ack_meta_q <= GPIO_ACK_IN;
      ack_s_q    <= ack_meta_q;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      stb_q      <= stb_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign timeout_err  = err_q;
  assign GPIO_TX_DATA = data_q;
  assign GPIO_TX_STB  = stb_q;
  assign LEDR         = {sticky_q, 4'b0000, ack_s_q, stb_q, data_q};

endmodule

// File: tb/tb_gpio_box_tx.sv
module tb_gpio_box_tx;

  localparam int S = 4;
  localparam int T = 20;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       send_req = 1'b0;
  logic [2:0] send_addr = 3'b000;
  logic       ack = 1'b0;
  logic       busy, done, timeout_err, stb;
  logic [2:0] data;
  logic [9:0] ledr;

  always #5 clk = ~clk;

  gpio_box_tx #(.SETUP_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .CLOCK_50    (clk),
    .resetn      (resetn),
    .send_req    (send_req),
    .send_addr   (send_addr),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .GPIO_TX_DATA(data),
    .GPIO_TX_STB (stb),
    .GPIO_ACK_IN (ack),
    .LEDR        (ledr)
  );

  typedef struct {
    logic [2:0] addr;
    bit         is_err;
    int         width;   // clocks the strobe is high
    int         rise;    // clocks from accepting edge to strobe high
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   txn_id = 0;

  function automatic void check(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Ack as the FPGA should see it: the pin value two rising edges ago.
  bit as1 = 1'b0, as2 = 1'b0;
  always @(posedge clk) begin
    cyc++;
    if (!resetn) begin
      as1 = 1'b0;
      as2 = 1'b0;
    end else begin
      as2 = as1;
      as1 = ack;
    end
  end

  // Monitor: tracks strobe timing per transaction and scores each done/timeout pulse.
  bit busy_prev = 1'b0;
  bit pulse_prev = 1'b0;
  int t0 = 0, width = 0, rise = -1;
  always @(negedge clk) begin
    exp_t e;
    check("ledr_ack_s", int'(ledr[4]), int'(as2));
    check("ledr_unused", int'(ledr[8:5]), 0);
    if (pulse_prev) begin
      check("done_1cycle", int'(done), 0);
      check("err_1cycle", int'(timeout_err), 0);
      check("busy_after_end", int'(busy), 0);
    end
    if (busy && !busy_prev) begin
      t0 = cyc - 1;
      width = 0;
      rise = -1;
    end
    if (stb) begin
      width++;
      if (rise < 0) rise = cyc - t0;
    end
    if (busy && exp_q.size() > 0) check("data_held", int'(data), int'(exp_q[0].addr));
    pulse_prev = 1'b0;
    if (done || timeout_err) begin
      pulse_prev = 1'b1;
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        e = exp_q.pop_front();
        $display("txn addr=%0d %s strobe_width=%0d rise=%0d", e.addr,
                 timeout_err ? "timeout" : "done", width, rise);
        check("outcome_err", int'(timeout_err), int'(e.is_err));
        check("outcome_done", int'(done), int'(!e.is_err));
        check("pulse_addr", int'(data), int'(e.addr));
        check("ledr_addr", int'(ledr[2:0]), int'(e.addr));
        check("strobe_width", width, e.width);
        if (e.width > 0) check("strobe_rise", rise, e.rise);
        check("strobe_low_at_end", int'(stb), 0);
        check("ledr_stb", int'(ledr[3]), 0);
        check("sticky", int'(ledr[9]), int'(e.is_err));
      end
    end
    busy_prev = busy;
  end

  // One handshake. a<0 means the MCU never acks. Entered and left at posedge+1.
  task automatic run_txn(input logic [2:0] addr, input bit stale, input int l,
                         input int a, input int r, input bit glitch, input bit extra_req);
    exp_t e;
    int   sx;
    bit   found;
    sx = S - 1;
    if (stale && (l + 2) > sx) sx = l + 2;
    e.addr = addr;
    e.rise = sx + 2;
    if (sx > T - 1) begin
      e.is_err = 1'b1; e.width = 0;
    end else if (a < 0 || a > T - 4) begin
      e.is_err = 1'b1; e.width = T;
    end else begin
      e.width = a + 4; e.is_err = (r > T - 4);
    end
    txn_id++;

    if (stale) begin
      ack = 1'b1;
      repeat (3) @(posedge clk);
      #1;
    end
    exp_q.push_back(e);
    send_addr = addr;
    send_req = 1'b1;
    @(posedge clk);           // accepting edge
    #1;
    send_req = 1'b0;
    send_addr = 3'($urandom);
    if (stale) begin
      repeat (l) @(posedge clk);
      #1 ack = 1'b0;
    end else if (extra_req) begin
      repeat (2) @(posedge clk);
      #1;
      send_addr = ~addr;
      send_req = 1'b1;
      @(posedge clk);
      #1 send_req = 1'b0;
    end

    found = 1'b0;
    for (int k = 0; k < T + 8; k++) begin
      if (stb) begin found = 1'b1; break; end
      @(posedge clk);
      #1;
    end
    if (found && a >= 0) begin
      if (glitch && a >= 2) begin
        @(posedge clk);
        #2 ack = 1'b1;        // sub-cycle pulse between edges
        #2 ack = 1'b0;
        repeat (a - 1) @(posedge clk);
      end else begin
        repeat (a) @(posedge clk);
      end
      #1 ack = 1'b1;
      found = 1'b0;
      for (int k = 0; k < T + 8; k++) begin
        if (!stb) begin found = 1'b1; break; end
        @(posedge clk);
        #1;
      end
      if (!found) check("strobe_fall_bound", 0, 1);
      repeat (r) @(posedge clk);
      #1 ack = 1'b0;
    end

    found = 1'b0;
    for (int k = 0; k < 4 * T + 30; k++) begin
      if (!busy) begin found = 1'b1; break; end
      @(posedge clk);
      #1;
    end
    if (!found) check("busy_release_bound", 0, 1);
    ack = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("data_kept_idle", int'(data), int'(addr));
    check("sticky_idle", int'(ledr[9]), int'(e.is_err));
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    check({tag, "_strobe"}, int'(stb), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_terr"}, int'(timeout_err), 0);
    check({tag, "_data"}, int'(data), 0);
    check({tag, "_ledr"}, int'(ledr), 0);
  endtask

  initial begin
    int a, r;
    bit st, found;
    repeat (3) @(posedge clk);
    check_reset_state("reset");
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Directed cases.
    run_txn(3'b101, 0, 0, 3, 3, 0, 0);    // basic handshake
    run_txn(3'b101, 0, 0, 5, 2, 0, 1);    // ignored second request (addr 010)
    run_txn(3'b110, 0, 0, -1, 0, 0, 0);   // ack never arrives
    run_txn(3'b001, 0, 0, 2, 1, 0, 0);    // clears sticky error
    run_txn(3'b011, 1, 6, 2, 1, 0, 0);    // stale ack released in SETUP
    run_txn(3'b100, 1, 17, 1, 1, 0, 0);   // stale release on the last setup cycle
    run_txn(3'b111, 1, 18, 1, 1, 0, 0);   // stale release too late
    run_txn(3'b010, 0, 0, 16, 4, 0, 0);   // ack on the last strobe cycle wins
    run_txn(3'b010, 0, 0, 17, 4, 0, 0);   // ack one clock too late
    run_txn(3'b110, 0, 0, 4, 16, 0, 0);   // ack drop on the last release cycle
    run_txn(3'b011, 0, 0, 4, 17, 0, 0);   // ack drop too late
    run_txn(3'b101, 0, 0, 6, 2, 1, 0);    // sub-cycle ack glitch ignored

    // Reset while the strobe is high.
    send_addr = 3'b111;
    send_req = 1'b1;
    @(posedge clk);
    #1 send_req = 1'b0;
    found = 1'b0;
    for (int k = 0; k < T; k++) begin
      if (stb) begin found = 1'b1; break; end
      @(posedge clk);
      #1;
    end
    check("reset_test_strobe_seen", int'(found), 1);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b0;
    @(posedge clk);
    check_reset_state("midreset");
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Randomised traffic.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0:       a = -1;
        1:       a = int'($urandom_range(17, 19));
        default: a = int'($urandom_range(0, 16));
      endcase
      r  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(17, 19)) : int'($urandom_range(0, 16));
      st = ($urandom_range(0, 3) == 0);
      run_txn(3'($urandom), st, int'($urandom_range(0, 19)), a, r,
              1'($urandom), st ? 1'b0 : 1'($urandom));
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
